// File: rtl/stack_unit_pkg.sv
// Shared definitions for the PUSH/POP/CALL/RET stack sequencer.
package stack_unit_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StRdWait,
    StSpwb,
    StDone,
    StErr
  } state_e;

  localparam logic [7:0] STACK_LIMIT_DEFAULT = 8'h80;
  localparam logic [7:0] SP_TOP_DEFAULT      = 8'hFF;
  localparam logic [1:0] SP_IDX_DEFAULT      = 2'b11;

  function automatic logic op_is_write(input op_e op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/stack_limit_chk.sv
// Overflow/underflow detection for a stack request against the current SP.
module stack_limit_chk
  import stack_unit_pkg::*;
#(
  parameter int unsigned       DATA_W      = 8,
  parameter logic [DATA_W-1:0] STACK_LIMIT = DATA_W'(STACK_LIMIT_DEFAULT),
  parameter logic [DATA_W-1:0] SP_TOP      = DATA_W'(SP_TOP_DEFAULT)
) (
  input  op_e               i_op,
  input  logic [DATA_W-1:0] i_sp,
  output logic              o_is_write,
  output logic              o_err
);

  assign o_is_write = op_is_write(i_op);
  // Full stack refuses writes; empty stack refuses reads.
  assign o_err      = o_is_write ? (i_sp == STACK_LIMIT) : (i_sp == SP_TOP);

endmodule

// File: rtl/stack_unit.sv
// Stack sequencer: memory access for PUSH/POP/CALL/RET plus SP write-back via the RF port.
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int unsigned       DATA_W      = 8,
  parameter logic [DATA_W-1:0] STACK_LIMIT = DATA_W'(STACK_LIMIT_DEFAULT),
  parameter logic [DATA_W-1:0] SP_TOP      = DATA_W'(SP_TOP_DEFAULT),
  parameter logic [1:0]        SP_IDX      = SP_IDX_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_op,
  input  logic [DATA_W-1:0] i_req_data,
  input  logic [DATA_W-1:0] i_sp_in,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_rf_wr_en,
  output logic [1:0]        o_rf_wr_addr,
  output logic [DATA_W-1:0] o_rf_wr_data,
  input  logic              i_rf_wr_gnt,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_jump,
  output logic              o_rsp_err
);

  localparam logic [DATA_W-1:0] LP_ONE = DATA_W'(1);

  state_e            r_state;
  op_e               r_op;
  logic [DATA_W-1:0] r_sp;
  logic [DATA_W-1:0] r_new_sp;
  logic [DATA_W-1:0] r_rdata;

  logic w_is_write;
  logic w_limit_err;

  stack_limit_chk #(
    .DATA_W      (DATA_W),
    .STACK_LIMIT (STACK_LIMIT),
    .SP_TOP      (SP_TOP)
  ) u_limit_chk (
    .i_op       (op_e'(i_req_op)),
    .i_sp       (i_sp_in),
    .o_is_write (w_is_write),
    .o_err      (w_limit_err)
  );

  // Outputs are registered: each transition loads the outputs of the state being entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_op         <= OP_PUSH;
      r_sp         <= '0;
      r_new_sp     <= '0;
      r_rdata      <= '0;
      o_req_ready  <= 1'b1;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_mem_we     <= 1'b0;
      o_mem_re     <= 1'b0;
      o_rf_wr_en   <= 1'b0;
      o_rf_wr_addr <= '0;
      o_rf_wr_data <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_data   <= '0;
      o_rsp_jump   <= 1'b0;
      o_rsp_err    <= 1'b0;
    end else begin
      o_req_ready  <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_mem_we     <= 1'b0;
      o_mem_re     <= 1'b0;
      o_rf_wr_en   <= 1'b0;
      o_rf_wr_addr <= '0;
      o_rf_wr_data <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_data   <= '0;
      o_rsp_jump   <= 1'b0;
      o_rsp_err    <= 1'b0;
      unique case (r_state)
        StIdle: begin
          o_req_ready <= 1'b1;
          if (i_req_valid) begin
            r_op        <= op_e'(i_req_op);
            r_sp        <= i_sp_in;
            o_req_ready <= 1'b0;
            if (w_limit_err) begin
              r_state     <= StErr;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
            end else if (w_is_write) begin
              r_state     <= StWrite;
              o_mem_we    <= 1'b1;
              o_mem_addr  <= i_sp_in;
              o_mem_wdata <= i_req_data;
            end else begin
              r_state    <= StRead;
              o_mem_re   <= 1'b1;
              o_mem_addr <= i_sp_in + LP_ONE;
            end
          end
        end
        StWrite: begin
          r_state      <= StSpwb;
          r_new_sp     <= r_sp - LP_ONE;
          o_rf_wr_en   <= 1'b1;
          o_rf_wr_addr <= SP_IDX;
          o_rf_wr_data <= r_sp - LP_ONE;
        end
        StRead: begin
          r_state  <= StRdWait;
          r_new_sp <= r_sp + LP_ONE;
        end
        StRdWait: begin
          r_state      <= StSpwb;
          r_rdata      <= i_mem_rdata;
          o_rf_wr_en   <= 1'b1;
          o_rf_wr_addr <= SP_IDX;
          o_rf_wr_data <= r_new_sp;
        end
        StSpwb: begin
          if (i_rf_wr_gnt) begin
            r_state     <= StDone;
            o_rsp_valid <= 1'b1;
            o_rsp_data  <= op_is_write(r_op) ? '0 : r_rdata;
            o_rsp_jump  <= (r_op == OP_RET);
          end else begin
            o_rf_wr_en   <= 1'b1;
            o_rf_wr_addr <= SP_IDX;
            o_rf_wr_data <= r_new_sp;
          end
        end
        StDone, StErr: begin
          r_state     <= StIdle;
          o_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= StIdle;
          o_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
